apb_write_decoder: RTL and testbench

- APB (AMBA 3 style) write-only slave with an address decoder in front of a small register file of NUM_REGS byte registers.
- Accepts zero-wait-state write transfers, stores PWDATA into the register selected by PADDR, and flags PSLVERR for illegal transfers.
- Sits on a peripheral APB segment behind the bridge.
- A side-band debug port exposes register contents for checking.

---
 rtl/apb_write_decoder.sv | 113 +++++++++++
 tb/tb_apb_write_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apb_write_decoder.sv
// ----------------------------------------------------------------------------
// apb_write_decoder
//
// Purpose:
//   APB (AMBA 3 style) write-only slave. An address decoder sits in front of
//   a small register file of NUM_REGS registers. The slave accepts
//   zero-wait-state write transfers and stores PWDATA into the register
//   selected by PADDR. It raises PSLVERR for reads and for out-of-range
//   addresses. A side-band debug port exposes the register contents.
//
// Ports:
//   PCLK      in   single clock, rising edge
//   PRESETn   in   synchronous reset, ACTIVE-HIGH despite the name
//   PSEL      in   slave select
//   PENABLE   in   access-phase strobe
//   PWRITE    in   1 = write, 0 = read (reads are answered with PSLVERR)
//   PADDR     in   [ADDR_W-1:0] register address
//   PWDATA    in   [DATA_W-1:0] write data
//   PREADY    out  transfer complete (combinational, no wait states)
//   PSLVERR   out  error response, only ever 1 while PREADY is 1
//   dbg_addr  in   [ADDR_W-1:0] debug read index
//   dbg_rdata out  [DATA_W-1:0] regs[dbg_addr], or 0 when out of range
// ----------------------------------------------------------------------------
module apb_write_decoder #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    // Index width into the register file. The range checks below guard every
    // access, so the array may be smaller than 2**IDX_W.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // NUM_REGS widened by one bit so the range comparison stays exact even
    // when NUM_REGS equals 2**ADDR_W.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic {
        IDLE  = 1'b0,
        SETUP = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    logic acc;
    logic addr_ok;
    logic dbg_ok;
    logic commit;

    // Decode. PADDR, PWDATA and PWRITE matter only during the access cycle.
    assign acc     = (state == SETUP) && PSEL && PENABLE;
    assign addr_ok = {1'b0, PADDR} < NUM_REGS_W;
    assign commit  = acc && PWRITE && addr_ok;

    assign PREADY  = acc;
    assign PSLVERR = acc && (!PWRITE || !addr_ok);

    // Phase tracking. A setup cycle holds SETUP for as long as PENABLE stays
    // low. Any other combination returns to IDLE. This covers a PSEL drop in
    // setup, a completed access, and a stray PENABLE with no prior setup.
    // NOTE: clocked state uses non-blocking assignments. This keeps every
    // flop reading pre-edge values, regardless of block ordering.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state <= IDLE;
        end else if (PSEL && !PENABLE) begin
            state <= SETUP;
        end else begin
            state <= IDLE;
        end
    end

    // Register file. Reset is checked first, so a reset that coincides with
    // an access cycle aborts the write.
    // NOTE: this storage is deliberately reset, because software expects
    // zeros after reset. That forces flops rather than a RAM macro, which
    // is acceptable at this size.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[PADDR[IDX_W-1:0]] <= PWDATA;
        end
    end

    // Debug read port. Out-of-range indices read as zero.
    assign dbg_ok = {1'b0, dbg_addr} < NUM_REGS_W;

    // NOTE: the default assignment comes first, so every path through the
    // block drives dbg_rdata and no latch is inferred.
    always_comb begin
        dbg_rdata = '0;
        if (dbg_ok) begin
            dbg_rdata = regs[dbg_addr[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_apb_write_decoder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_apb_write_decoder
//
// Directed bench for apb_write_decoder. Each bus cycle pushes the expected
// {PREADY, PSLVERR} pair onto a scoreboard queue. The pair is popped and
// compared once the DUT outputs have settled mid-cycle. A bench-side model
// of the register file is compared through the debug port.
// ----------------------------------------------------------------------------
module tb_apb_write_decoder;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;

    typedef struct {
        logic rdy;
        logic err;
    } bus_exp_t;

    bus_exp_t          sb [$];
    logic [DATA_W-1:0] model [0:NUM_REGS-1];

    int total = 0;
    int bad   = 0;

    apb_write_decoder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

    // Rising edges fall at 50, 150, 250, ... Inputs change just after each
    // falling edge.
    always #50 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle. When chk is set, the expected response is pushed
    // to the scoreboard, then popped and compared after the outputs settle.
    task automatic cycle(input string tag, input logic rst, input logic sel,
                         input logic en, input logic wr,
                         input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data,
                         input logic chk, input logic exp_rdy,
                         input logic exp_err);
        bus_exp_t e;
        @(negedge PCLK);
        PRESETn = rst;
        PSEL    = sel;
        PENABLE = en;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        if (chk) sb.push_back('{rdy: exp_rdy, err: exp_err});
        #1;
        if (chk) begin
            if (sb.size() == 0) begin
                check({tag, " scoreboard empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({tag, " PREADY"},  {31'd0, PREADY},  {31'd0, e.rdy});
                check({tag, " PSLVERR"}, {31'd0, PSLVERR}, {31'd0, e.err});
            end
        end
    endtask

    // Compare every register, plus two out-of-range debug indices.
    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_addr = ADDR_W'(i);
            #1;
            check($sformatf("%s dbg[%0d]", tag, i), {24'd0, dbg_rdata}, {24'd0, model[i]});
        end
        dbg_addr = 8'h08;
        #1;
        check({tag, " dbg[0x08]"}, {24'd0, dbg_rdata}, 32'd0);
        dbg_addr = 8'hFF;
        #1;
        check({tag, " dbg[0xFF]"}, {24'd0, dbg_rdata}, 32'd0);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        PRESETn  = 1'b1;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        dbg_addr = '0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // Reset for one edge, then everything reads zero.
        cycle("reset", 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("post_reset");
        check_regs("post_reset");

        // Single write to 0x03.
        cycle("wr3 setup",  1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'hA5, 1'b1, 1'b0, 1'b0);
        cycle("wr3 access", 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'hA5, 1'b1, 1'b1, 1'b0);
        model[3] = 8'hA5;
        idle("wr3 idle");
        check_regs("wr3");

        // Out-of-range writes: 0x08 and 0xFF complete with an error.
        cycle("oor8 setup",  1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h5A, 1'b1, 1'b0, 1'b0);
        cycle("oor8 access", 1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 8'h5A, 1'b1, 1'b1, 1'b1);
        cycle("oorF setup",  1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h5A, 1'b1, 1'b0, 1'b0);
        cycle("oorF access", 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h5A, 1'b1, 1'b1, 1'b1);
        idle("oor idle");
        check_regs("oor");

        // Setup values are ignored: setup shows 0x05/0x00, access uses 0x02/0x3C.
        cycle("wr2 setup",  1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("wr2 access", 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 8'h3C, 1'b1, 1'b1, 1'b0);
        model[2] = 8'h3C;

        // Read attempt on 0x02 errors and leaves regs[2] alone.
        cycle("rd2 setup",  1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("rd2 access", 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b1, 1'b1);
        idle("rd2 idle");
        check_regs("rd2");

        // Back-to-back writes: PREADY high on cycles 2 and 4.
        cycle("b2b c1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0);
        cycle("b2b c2", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h11, 1'b1, 1'b1, 1'b0);
        cycle("b2b c3", 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 8'hEE, 1'b1, 1'b0, 1'b0);
        cycle("b2b c4", 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 8'hEE, 1'b1, 1'b1, 1'b0);
        model[0] = 8'h11;
        model[7] = 8'hEE;
        idle("b2b idle");
        check_regs("b2b");

        // Setup held for two cycles, then the access to 0x06.
        cycle("hold s1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("hold s2", 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("hold acc", 1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 8'h66, 1'b1, 1'b1, 1'b0);
        model[6] = 8'h66;

        // PSEL dropped in setup. The next PSEL+PENABLE has no setup: no write.
        cycle("drop setup", 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 1'b0);
        cycle("drop nosel", 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 1'b0);
        cycle("drop enab",  1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 1'b0);

        // PENABLE with no setup cycle from IDLE: no transfer.
        idle("nosetup pre");
        cycle("nosetup", 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h99, 1'b1, 1'b0, 1'b0);
        idle("viol idle");
        check_regs("viol");

        // Reset during the access cycle of a write to 0x04: reset wins.
        // Outputs during the reset cycle itself are not constrained.
        cycle("rst setup", 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h44, 1'b1, 1'b0, 1'b0);
        cycle("rst access", 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 8'h44, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        idle("rst after");
        check_regs("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
